text_row_prefetch: RTL

Upstream feeder for the text-mode pixel renderer. It prefetches one full text row (80 characters, 20 packed 32-bit VRAM words) from VRAM into a ping-pong line buffer ahead of display, and serves words to the renderer from the display bank. The renderer indexes the buffer by character-word column instead of issuing VRAM reads per pixel. VRAM access competes with AXI writes through a request/grant handshake.

---
 rtl/text_row_prefetch_if.sv | 29 ++
 rtl/text_row_prefetch.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/text_row_prefetch_if.sv
// text_row_prefetch_if
// VRAM read port shared between the row prefetcher and the VRAM arbiter.
//   vram_rd_en    request valid, held until granted
//   vram_rd_addr  word address of the request
//   vram_gnt      request accepted this cycle when vram_rd_en & vram_gnt
//   vram_rd_data  read data, valid a fixed latency after acceptance
// master = requester (prefetcher), slave = VRAM/arbiter side.
interface text_row_prefetch_if #(
    parameter int VRAM_AW = 10
);
    logic               vram_rd_en;
    logic [VRAM_AW-1:0] vram_rd_addr;
    logic               vram_gnt;
    logic [31:0]        vram_rd_data;

    modport master (
        output vram_rd_en,
        output vram_rd_addr,
        input  vram_gnt,
        input  vram_rd_data
    );

    modport slave (
        input  vram_rd_en,
        input  vram_rd_addr,
        output vram_gnt,
        output vram_rd_data
    );
endinterface

// File: rtl/text_row_prefetch.sv
// text_row_prefetch
// Prefetches one text row (WORDS_PER_ROW packed 32-bit words) from VRAM into
// the fill half of a ping-pong line buffer and serves the display half to the
// text renderer, indexed by word column.
//
// Ports:
//   axi_aclk      clock
//   axi_aresetn   asynchronous active-low reset
//   line_start    one-cycle pulse at the start of each scanline
//   drawY         scanline index, valid with line_start
//   vram          VRAM read port (master side of text_row_prefetch_if)
//   rd_word_idx   renderer word column
//   rd_word       registered display-bank word (0 when no row or column out of range)
//   row_valid     display bank holds a completed row
//   fetch_busy    row fetch in progress
//   err_underrun  sticky: a row boundary arrived before the fetch completed
//
// FSM states:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | no fetch; waits for a trigger decoded from line_start
//   S_REQ   | issuing word requests, address held until granted
//   S_DRAIN | all requests accepted; waiting for the last returns
module text_row_prefetch #(
    parameter int WORDS_PER_ROW = 20,
    parameter int ROWS          = 30,
    parameter int V_ACTIVE      = 480,
    parameter int VRAM_AW       = 10,
    parameter int RD_LAT        = 2
) (
    input  logic                axi_aclk,
    input  logic                axi_aresetn,
    input  logic                line_start,
    input  logic [9:0]          drawY,
    text_row_prefetch_if.master vram,
    input  logic [4:0]          rd_word_idx,
    output logic [31:0]         rd_word,
    output logic                row_valid,
    output logic                fetch_busy,
    output logic                err_underrun
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [4:0]  row_q;
    logic [4:0]  w_q;
    logic        disp_bank;
    logic        fill_done;

    // Return tracking: stage RD_LAT-1 lines up with vram_rd_data.
    logic [RD_LAT-1:0] pipe_v;
    logic [4:0]        pipe_w [RD_LAT];

    logic [31:0] line_buf [2][WORDS_PER_ROW];

    logic [5:0] y_row;
    logic [4:0] trig_row;
    logic       is_vend;
    logic       is_row_evt;
    logic       swap;
    logic       trigger;
    logic       accept;
    logic       last_word;
    logic       early_pend;
    logic       drain_done;

    assign y_row      = drawY[9:4];
    assign is_vend    = line_start && (drawY == 10'(V_ACTIVE));
    assign is_row_evt = line_start && (drawY < 10'(V_ACTIVE)) && (drawY[3:0] == 4'd0);
    assign swap       = is_row_evt && fill_done;
    // Only an idle prefetcher accepts a trigger; triggers are never queued.
    assign trigger    = (state_q == S_IDLE) &&
                        (is_vend || (swap && ((int'(y_row) + 1) < ROWS)));
    assign trig_row   = is_vend ? 5'd0 : 5'(y_row + 6'd1);
    assign accept     = (state_q == S_REQ) && vram.vram_gnt;
    assign last_word  = (w_q == 5'(WORDS_PER_ROW - 1));

    // The last stage is being written this cycle, so the pipeline is empty
    // next cycle when all earlier stages are empty.
    always_comb begin
        early_pend = 1'b0;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            early_pend = early_pend | pipe_v[i];
        end
    end

    assign drain_done = (state_q == S_DRAIN) && !early_pend;

    // State register
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (trigger) state_d = S_REQ;
            S_REQ:   if (accept && last_word) state_d = S_DRAIN;
            S_DRAIN: if (drain_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        vram.vram_rd_en   = (state_q == S_REQ);
        vram.vram_rd_addr = '0;
        if (state_q == S_REQ) begin
            vram.vram_rd_addr = VRAM_AW'(row_q) * VRAM_AW'(WORDS_PER_ROW) + VRAM_AW'(w_q);
        end
        fetch_busy = (state_q != S_IDLE);
    end

    // Fetch bookkeeping, bank control and return pipeline
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            row_q        <= '0;
            w_q          <= '0;
            disp_bank    <= 1'b0;
            fill_done    <= 1'b0;
            row_valid    <= 1'b0;
            err_underrun <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_w[i] <= '0;
            end
        end else begin
            if (drain_done) begin
                fill_done <= 1'b1;
            end
            if (swap) begin
                disp_bank <= ~disp_bank;
                row_valid <= 1'b1;
                fill_done <= 1'b0;
            end
            if (is_row_evt && !fill_done) begin
                err_underrun <= 1'b1;
            end
            // A new fill overwrites the fill bank, so it is no longer complete.
            if (trigger) begin
                row_q     <= trig_row;
                w_q       <= '0;
                fill_done <= 1'b0;
            end else if (accept) begin
                w_q <= w_q + 5'd1;
            end
            pipe_v[0] <= accept;
            pipe_w[0] <= w_q;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_w[i] <= pipe_w[i-1];
            end
        end
    end

    // Buffer RAM, not reset. The display bank cannot change while returns
    // are in flight (a swap needs fill_done), so ~disp_bank is the fill bank.
    always_ff @(posedge axi_aclk) begin
        if (pipe_v[RD_LAT-1]) begin
            line_buf[~disp_bank][pipe_w[RD_LAT-1]] <= vram.vram_rd_data;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            rd_word <= '0;
        end else if (row_valid && (rd_word_idx < 5'(WORDS_PER_ROW))) begin
            rd_word <= line_buf[disp_bank][rd_word_idx];
        end else begin
            rd_word <= '0;
        end
    end

endmodule
